// File: rtl/wav_pkt_pkg.sv
// Shared types and constants for the WAV-to-UDP packer.
// WAV_PKT_SEQ_HDR_EN adds a 32-bit sequence header ahead of the payload.
package wav_pkt_pkg;

    localparam int unsigned SEQ_HDR_W   = 32;
    localparam int unsigned FRAME_IDX_W = 10;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap
    } fsm_state_e;

    typedef enum logic [1:0] {
        BufEmpty,
        BufFilling,
        BufFull
    } buf_state_e;

    function automatic int unsigned pkt_width(input int unsigned pay_bits);
`ifdef WAV_PKT_SEQ_HDR_EN
        return pay_bits + SEQ_HDR_W;
`else
        return pay_bits;
`endif
    endfunction

endpackage

// File: rtl/wav_pkt_packer_if.sv
// Frame input and UDP payload output bundle of the packer.
interface wav_pkt_packer_if #(
    parameter int unsigned CH_NUM         = 2,
    parameter int unsigned SAMPLE_W       = 16,
    parameter int unsigned FRAMES_PER_PKT = 240
);
    import wav_pkt_pkg::*;

    localparam int unsigned PKT_W = pkt_width(CH_NUM * SAMPLE_W * FRAMES_PER_PKT);

    logic [CH_NUM*SAMPLE_W-1:0] wav_in_data;
    logic                       wav_wren;
    logic                       wav_drop;
    logic [15:0]                drop_cnt;
    logic                       udp_send_data_valid;
    logic                       udp_send_data_ready;
    logic [PKT_W-1:0]           udp_send_data;
    logic [15:0]                udp_send_data_length;

    modport master (
        input  wav_in_data, wav_wren, udp_send_data_ready,
        output wav_drop, drop_cnt, udp_send_data_valid, udp_send_data, udp_send_data_length
    );

    modport slave (
        output wav_in_data, wav_wren, udp_send_data_ready,
        input  wav_drop, drop_cnt, udp_send_data_valid, udp_send_data, udp_send_data_length
    );

endinterface

// File: rtl/wav_pkt_buf.sv
// One payload buffer: frame-indexed write port, FULL flag, parallel read of the whole payload.
module wav_pkt_buf #(
    parameter int unsigned FRAME_W = 32,
    parameter int unsigned FRAMES  = 240,
    parameter int unsigned IDX_W   = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic [FRAME_W-1:0]        wr_data,
    input  logic                      wr_last,
    input  logic                      clr,
    output logic                      full,
    output logic [FRAME_W*FRAMES-1:0] data
);
    localparam int unsigned PAY_W = FRAME_W * FRAMES;

    logic [PAY_W-1:0] data_q;
    logic [PAY_W-1:0] wr_mask;
    logic [PAY_W-1:0] wr_word;
    logic [31:0]      wr_shift;
    logic             full_q;

    // Frame 0 lands in the MSBs, so the shift shrinks as the index grows.
    always_comb begin
        wr_shift = (FRAMES - 1 - 32'(wr_idx)) * FRAME_W;
        wr_mask  = PAY_W'({FRAME_W{1'b1}}) << wr_shift;
        wr_word  = PAY_W'(wr_data) << wr_shift;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            if (wr_en) begin
                data_q <= (data_q & ~wr_mask) | wr_word;
            end
            if (clr) begin
                full_q <= 1'b0;
            end else if (wr_en && wr_last) begin
                full_q <= 1'b1;
            end
        end
    end

    assign full = full_q;
    assign data = data_q;

endmodule

// File: rtl/wav_pkt_packer.sv
// Packs audio frames into ping/pong UDP payloads with a valid/ready output FSM.
// Define WAV_PKT_SEQ_HDR_EN to prefix each payload with a 32-bit sequence number.
module wav_pkt_packer
    import wav_pkt_pkg::*;
#(
    parameter int unsigned CH_NUM         = 2,
    parameter int unsigned SAMPLE_W       = 16,
    parameter int unsigned FRAMES_PER_PKT = 240
) (
    input  logic             clk,
    input  logic             rst_n,
    wav_pkt_packer_if.master bus
);
    localparam int unsigned FRAME_W = CH_NUM * SAMPLE_W;
    localparam int unsigned PAY_W   = FRAME_W * FRAMES_PER_PKT;
    localparam int unsigned PKT_W   = pkt_width(PAY_W);
    localparam logic [15:0] PKT_LEN = 16'(PKT_W / 8);

    if ((PAY_W % 8) != 0) begin : g_len_chk
        $error("CH_NUM*SAMPLE_W*FRAMES_PER_PKT must be a multiple of 8");
    end
    if (FRAMES_PER_PKT < 1 || FRAMES_PER_PKT > 1023) begin : g_frames_chk
        $error("FRAMES_PER_PKT must be within 1..1023");
    end

    fsm_state_e             state_q, state_d;
    logic                   fill_valid_q, fill_valid_d;
    logic                   fill_sel_q, fill_sel_d;
    logic                   send_sel_q, send_sel_d;
    logic                   older_q, older_d;
    logic [FRAME_IDX_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   wav_drop_q, wav_drop_d;
    logic [15:0]            drop_cnt_q, drop_cnt_d;

    logic [1:0]       buf_full, buf_wr, buf_clr, full_nx;
    logic [PAY_W-1:0] buf_data [2];
    buf_state_e       buf_st [2];
    logic             frame_wr, frame_last, handshake, other;

    assign handshake  = (state_q == StSend) && bus.udp_send_data_ready;
    assign frame_wr   = bus.wav_wren && fill_valid_q;
    assign frame_last = frame_cnt_q == FRAME_IDX_W'(FRAMES_PER_PKT - 1);
    assign other      = ~fill_sel_q;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            if (buf_full[i]) begin
                buf_st[i] = BufFull;
            end else if (fill_valid_q && fill_sel_q == 1'(i)) begin
                buf_st[i] = BufFilling;
            end else begin
                buf_st[i] = BufEmpty;
            end
            buf_wr[i]  = frame_wr && fill_sel_q == 1'(i);
            buf_clr[i] = handshake && send_sel_q == 1'(i);
            // Full as of the next edge: lets valid rise right after the completing write.
            full_nx[i] = (buf_full[i] && !buf_clr[i]) || (buf_wr[i] && frame_last);
        end
    end

    always_comb begin
        fill_valid_d = fill_valid_q;
        fill_sel_d   = fill_sel_q;
        frame_cnt_d  = frame_cnt_q;
        older_d      = older_q;
        if (frame_wr) begin
            if (frame_last) begin
                frame_cnt_d = '0;
                // A buffer freed by this cycle's handshake is already usable.
                if (buf_st[other] == BufEmpty || buf_clr[other]) begin
                    fill_sel_d = other;
                end else begin
                    fill_valid_d = 1'b0;
                end
                if (!(buf_full[other] && !buf_clr[other])) begin
                    older_d = fill_sel_q;
                end
            end else begin
                frame_cnt_d = frame_cnt_q + FRAME_IDX_W'(1);
            end
        end else if (!fill_valid_q && handshake) begin
            fill_valid_d = 1'b1;
            fill_sel_d   = send_sel_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        send_sel_d = send_sel_q;
        unique case (state_q)
            StIdle, StGap: begin
                if (|full_nx) begin
                    state_d    = StSend;
                    send_sel_d = (&full_nx) ? older_d : full_nx[1];
                end else begin
                    state_d = StIdle;
                end
            end
            StSend: begin
                if (bus.udp_send_data_ready) begin
                    state_d = StGap;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wav_drop_d = bus.wav_wren && !fill_valid_q;
        drop_cnt_d = drop_cnt_q;
        if (wav_drop_d && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            fill_valid_q <= 1'b1;
            fill_sel_q   <= 1'b0;
            send_sel_q   <= 1'b0;
            older_q      <= 1'b0;
            frame_cnt_q  <= '0;
            wav_drop_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            fill_valid_q <= fill_valid_d;
            fill_sel_q   <= fill_sel_d;
            send_sel_q   <= send_sel_d;
            older_q      <= older_d;
            frame_cnt_q  <= frame_cnt_d;
            wav_drop_q   <= wav_drop_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    wav_pkt_buf #(
        .FRAME_W (FRAME_W),
        .FRAMES  (FRAMES_PER_PKT),
        .IDX_W   (FRAME_IDX_W)
    ) u_ping (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (buf_wr[0]),
        .wr_idx  (frame_cnt_q),
        .wr_data (bus.wav_in_data),
        .wr_last (frame_last),
        .clr     (buf_clr[0]),
        .full    (buf_full[0]),
        .data    (buf_data[0])
    );

    wav_pkt_buf #(
        .FRAME_W (FRAME_W),
        .FRAMES  (FRAMES_PER_PKT),
        .IDX_W   (FRAME_IDX_W)
    ) u_pong (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (buf_wr[1]),
        .wr_idx  (frame_cnt_q),
        .wr_data (bus.wav_in_data),
        .wr_last (frame_last),
        .clr     (buf_clr[1]),
        .full    (buf_full[1]),
        .data    (buf_data[1])
    );

`ifdef WAV_PKT_SEQ_HDR_EN
    logic [SEQ_HDR_W-1:0] seq_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seq_q <= '0;
        end else if (handshake) begin
            seq_q <= seq_q + SEQ_HDR_W'(1);
        end
    end

    assign bus.udp_send_data = {seq_q, buf_data[send_sel_q]};
`else
    assign bus.udp_send_data = buf_data[send_sel_q];
`endif

    assign bus.udp_send_data_valid  = state_q == StSend;
    assign bus.udp_send_data_length = PKT_LEN;
    assign bus.wav_drop             = wav_drop_q;
    assign bus.drop_cnt             = drop_cnt_q;

endmodule
